// File: rtl/fir_unfold_scheduler.sv
// Sequencer for a 4-lane unfolded FIR: packs a serial stream into lanes, fires the core, re-serialises its outputs.
// Optional macro FIR_PIPE_EN adds one S_CAPT cycle for cores with registered products.
module fir_unfold_scheduler #(
    parameter int NB_DATA_IN  = 8,
    parameter int NB_DATA_OUT = 19,
    parameter int N_LANES     = 4
) (
    input  logic                          clock,
    input  logic                          i_reset,
    input  logic                          i_valid,
    output logic                          o_ready,
    input  logic signed [NB_DATA_IN-1:0]  i_data,
    output logic signed [NB_DATA_IN-1:0]  o_lane_0,
    output logic signed [NB_DATA_IN-1:0]  o_lane_1,
    output logic signed [NB_DATA_IN-1:0]  o_lane_2,
    output logic signed [NB_DATA_IN-1:0]  o_lane_3,
    output logic                          o_fir_enable,
    input  logic signed [NB_DATA_OUT-1:0] i_fir_0,
    input  logic signed [NB_DATA_OUT-1:0] i_fir_1,
    input  logic signed [NB_DATA_OUT-1:0] i_fir_2,
    input  logic signed [NB_DATA_OUT-1:0] i_fir_3,
    output logic                          o_valid,
    input  logic                          i_ready,
    output logic signed [NB_DATA_OUT-1:0] o_data,
    output logic                          o_busy
);

    typedef enum logic [1:0] {
        S_FILL = 2'd0,
        S_FIRE = 2'd1
`ifdef FIR_PIPE_EN
        , S_CAPT = 2'd2
`endif
    } state_t;

    state_t                        state_q, state_d;
    logic [1:0]                    in_cnt_q, in_cnt_d;
    logic [2:0]                    out_cnt_q, out_cnt_d;
    logic                          rdy_q;
    logic signed [NB_DATA_IN-1:0]  lane_q [N_LANES];
    logic signed [NB_DATA_IN-1:0]  lane_d [N_LANES];
    logic signed [NB_DATA_OUT-1:0] obuf_q [N_LANES];
    logic signed [NB_DATA_OUT-1:0] obuf_d [N_LANES];
    logic signed [NB_DATA_OUT-1:0] fir_in [N_LANES];
    logic signed [NB_DATA_OUT-1:0] o_data_q, o_data_d;

    assign fir_in[0] = i_fir_0;
    assign fir_in[1] = i_fir_1;
    assign fir_in[2] = i_fir_2;
    assign fir_in[3] = i_fir_3;

    // rdy_q keeps o_ready low for the reset cycle itself, since the state already reads S_FILL
    assign o_ready      = rdy_q && (state_q == S_FILL);
    assign o_fir_enable = (state_q == S_FIRE) && (out_cnt_q == 3'd0);
    assign o_valid      = (out_cnt_q != 3'd0);
    assign o_data       = o_data_q;
    assign o_busy       = (in_cnt_q != 2'd0) || (state_q != S_FILL) || (out_cnt_q != 3'd0);
    assign o_lane_0     = lane_q[0];
    assign o_lane_1     = lane_q[1];
    assign o_lane_2     = lane_q[2];
    assign o_lane_3     = lane_q[3];

    always_comb begin
        // NOTE: every variable gets its hold value first so no path can infer a latch.
        state_d   = state_q;
        in_cnt_d  = in_cnt_q;
        out_cnt_d = out_cnt_q;
        lane_d    = lane_q;
        obuf_d    = obuf_q;

        if (o_valid && i_ready)
            out_cnt_d = out_cnt_q - 3'd1;

        case (state_q)
            S_FILL: begin
                if (i_valid && o_ready) begin
                    lane_d[in_cnt_q] = i_data;
                    in_cnt_d         = 2'(in_cnt_q + 2'd1);
                    if (in_cnt_q == 2'd3)
                        state_d = S_FIRE;
                end
            end
            S_FIRE: begin
                // Firing waits for an empty output buffer, so a draining block is never overwritten
                if (out_cnt_q == 3'd0) begin
`ifdef FIR_PIPE_EN
                    state_d = S_CAPT;
`else
                    obuf_d    = fir_in;
                    out_cnt_d = 3'd4;
                    state_d   = S_FILL;
`endif
                end
            end
`ifdef FIR_PIPE_EN
            S_CAPT: begin
                obuf_d    = fir_in;
                out_cnt_d = 3'd4;
                state_d   = S_FILL;
            end
`endif
            default: state_d = S_FILL;
        endcase

        o_data_d = o_data_q;
        if (out_cnt_d != 3'd0)
            o_data_d = obuf_d[2'(3'd4 - out_cnt_d)];
    end

    always_ff @(posedge clock) begin
        // NOTE: lane and output buffers are reset too, because the lanes are visible outputs that must read zero.
        if (!i_reset) begin
            state_q   <= S_FILL;
            in_cnt_q  <= 2'd0;
            out_cnt_q <= 3'd0;
            rdy_q     <= 1'b0;
            o_data_q  <= '0;
            for (int k = 0; k < N_LANES; k++) begin
                lane_q[k] <= '0;
                obuf_q[k] <= '0;
            end
        end else begin
            state_q   <= state_d;
            in_cnt_q  <= in_cnt_d;
            out_cnt_q <= out_cnt_d;
            rdy_q     <= 1'b1;
            o_data_q  <= o_data_d;
            lane_q    <= lane_d;
            obuf_q    <= obuf_d;
        end
    end

endmodule

// File: tb/tb_fir_unfold_scheduler.sv
// Directed bench for fir_unfold_scheduler with an identity-coefficient FIR model.
// FIR_PIPE_EN, when defined, adds a one-cycle delay to the FIR model.
module tb_fir_unfold_scheduler;

    logic               clock;
    logic               i_reset;
    logic               i_valid;
    logic               o_ready;
    logic signed [7:0]  i_data;
    logic signed [7:0]  o_lane_0, o_lane_1, o_lane_2, o_lane_3;
    logic               o_fir_enable;
    logic signed [18:0] i_fir_0, i_fir_1, i_fir_2, i_fir_3;
    logic               o_valid;
    logic               i_ready;
    logic signed [18:0] o_data;
    logic               o_busy;

    int n_checks = 0;
    int n_fail   = 0;
    int fire_cnt = 0;
    int stall_cyc = 0;
    int got [$];
    int exp_q [$];
    logic               prev_stall = 1'b0;
    logic signed [18:0] prev_data = '0;

    fir_unfold_scheduler #(.NB_DATA_IN(8), .NB_DATA_OUT(19), .N_LANES(4)) dut (
        .clock(clock), .i_reset(i_reset), .i_valid(i_valid), .o_ready(o_ready), .i_data(i_data),
        .o_lane_0(o_lane_0), .o_lane_1(o_lane_1), .o_lane_2(o_lane_2), .o_lane_3(o_lane_3),
        .o_fir_enable(o_fir_enable),
        .i_fir_0(i_fir_0), .i_fir_1(i_fir_1), .i_fir_2(i_fir_2), .i_fir_3(i_fir_3),
        .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data), .o_busy(o_busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

`ifdef FIR_PIPE_EN
    logic signed [18:0] fir_q [4];
    initial for (int k = 0; k < 4; k++) fir_q[k] = '0;
    always @(posedge clock) begin
        if (o_fir_enable) begin
            fir_q[0] <= {{11{o_lane_0[7]}}, o_lane_0};
            fir_q[1] <= {{11{o_lane_1[7]}}, o_lane_1};
            fir_q[2] <= {{11{o_lane_2[7]}}, o_lane_2};
            fir_q[3] <= {{11{o_lane_3[7]}}, o_lane_3};
        end
    end
    assign i_fir_0 = fir_q[0];
    assign i_fir_1 = fir_q[1];
    assign i_fir_2 = fir_q[2];
    assign i_fir_3 = fir_q[3];
`else
    assign i_fir_0 = {{11{o_lane_0[7]}}, o_lane_0};
    assign i_fir_1 = {{11{o_lane_1[7]}}, o_lane_1};
    assign i_fir_2 = {{11{o_lane_2[7]}}, o_lane_2};
    assign i_fir_3 = {{11{o_lane_3[7]}}, o_lane_3};
`endif

    task automatic check(input string tag, input logic signed [31:0] act, input logic signed [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, req, $time);
        end
    endtask

    // Records handshakes and fire pulses, and checks o_data holds across a stall
    always @(posedge clock) begin
        if (!i_reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && o_valid)
                check("hold_data", o_data, prev_data);
            if (o_valid && i_ready)
                got.push_back(int'(o_data));
            if (o_fir_enable)
                fire_cnt++;
            if (i_valid && !o_ready)
                stall_cyc++;
            prev_stall = o_valid && !i_ready;
            prev_data  = o_data;
        end
    end

    // Called at a negedge; returns at the negedge after the sample is accepted
    task automatic send(input int x);
        int n = 0;
        i_valid = 1'b1;
        i_data  = 8'(x);
        while (!o_ready && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (n >= 50)
            check("send_timeout", o_ready, 1);
        @(negedge clock);
        i_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (o_busy && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (n >= 100)
            check("idle_timeout", o_busy, 0);
    endtask

    task automatic compare_out(input string tag);
        check({tag, "_count"}, got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            if (i < got.size())
                check(tag, got[i], exp_q[i]);
        got.delete();
        exp_q.delete();
    endtask

    initial begin
        i_reset = 1'b0;
        i_valid = 1'b0;
        i_data  = '0;
        i_ready = 1'b1;
        repeat (2) @(negedge clock);
        check("rst_ready", o_ready, 0);
        check("rst_valid", o_valid, 0);
        check("rst_fire", o_fir_enable, 0);
        check("rst_busy", o_busy, 0);
        check("rst_data", o_data, 0);
        check("rst_lane0", o_lane_0, 0);
        check("rst_lane3", o_lane_3, 0);
        i_reset = 1'b1;
        @(negedge clock);
        check("ready_after_rst", o_ready, 1);

        // Single block 1..4
        fire_cnt = 0;
        for (int v = 1; v <= 4; v++) send(v);
        check("t1_fire", o_fir_enable, 1);
        check("t1_ready_fire", o_ready, 0);
        check("t1_lane0", o_lane_0, 1);
        check("t1_lane1", o_lane_1, 2);
        check("t1_lane2", o_lane_2, 3);
        check("t1_lane3", o_lane_3, 4);
        @(negedge clock);
`ifdef FIR_PIPE_EN
        check("t1_capt_valid", o_valid, 0);
        check("t1_capt_ready", o_ready, 0);
        @(negedge clock);
`endif
        check("t1_latency_valid", o_valid, 1);
        check("t1_first_data", o_data, 1);
        wait_idle();
        for (int v = 1; v <= 4; v++) exp_q.push_back(v);
        compare_out("t1_out");
        check("t1_fire_cnt", fire_cnt, 1);

        // Continuous stream of 12 samples -10..1
        fire_cnt  = 0;
        stall_cyc = 0;
        for (int v = -10; v <= 1; v++) send(v);
        wait_idle();
        for (int v = -10; v <= 1; v++) exp_q.push_back(v);
        compare_out("t2_out");
        check("t2_fire_cnt", fire_cnt, 3);
`ifdef FIR_PIPE_EN
        check("t2_stalls", stall_cyc, 4);
`else
        check("t2_stalls", stall_cyc, 2);
`endif

        // Back-pressure: second block stalls in S_FIRE
        fire_cnt = 0;
        i_ready  = 1'b0;
        for (int v = 1; v <= 8; v++) send(v);
        check("t3_fire_cnt_stall", fire_cnt, 1);
        check("t3_ready_stall", o_ready, 0);
        check("t3_lane0", o_lane_0, 5);
        check("t3_lane3", o_lane_3, 8);
        for (int c = 0; c < 3; c++) begin
            check("t3_no_fire", o_fir_enable, 0);
            check("t3_valid_held", o_valid, 1);
            check("t3_data_held", o_data, 1);
            @(negedge clock);
        end
        i_ready = 1'b1;
        begin
            int n = 0;
            while (!o_fir_enable && n < 20) begin
                @(negedge clock);
                n++;
            end
            check("t3_fire_seen", o_fir_enable, 1);
            check("t3_fire_after_drain", o_valid, 0);
        end
        wait_idle();
        for (int v = 1; v <= 8; v++) exp_q.push_back(v);
        compare_out("t3_out");
        check("t3_fire_cnt", fire_cnt, 2);

        // Reset mid-block discards the partial block
        send(9);
        send(10);
        check("t4_busy_partial", o_busy, 1);
        i_reset = 1'b0;
        @(negedge clock);
        check("t4_busy_rst", o_busy, 0);
        check("t4_ready_rst", o_ready, 0);
        check("t4_lane0_rst", o_lane_0, 0);
        i_reset = 1'b1;
        for (int v = 5; v <= 8; v++) send(v);
        wait_idle();
        for (int v = 5; v <= 8; v++) exp_q.push_back(v);
        compare_out("t4_out");

        // Toggling i_ready during drain, with extreme sample values
        send(-128);
        send(127);
        send(0);
        send(-1);
        begin
            int n = 0;
            while (o_busy && n < 60) begin
                i_ready = ~i_ready;
                @(negedge clock);
                n++;
            end
            check("t5_drained", o_busy, 0);
        end
        i_ready = 1'b1;
        exp_q.push_back(-128);
        exp_q.push_back(127);
        exp_q.push_back(0);
        exp_q.push_back(-1);
        compare_out("t5_out");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
